replace_event_queue: RTL

REPLACE_EVENT_QUEUE -- requirements
Module: replace_event_queue

---
 rtl/replace_event_queue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/replace_event_queue.sv
// replace_event_queue: first-word-fall-through queue of decoded Replace Order
// events, each tagged with a 16-bit sequence number at push time.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid          decoded-message pulse; payload valid this cycle only
//   in_invalid        malformed-message pulse (counted, never queued)
//   in_old_ref/in_new_ref/in_shares/in_price   event payload
//   out_valid/out_ready                        head handshake
//   out_old_ref/out_new_ref/out_shares/out_price/out_seq   head entry (0 when empty)
//   count, full       occupancy and full flag
//   overflow          sticky: an event was dropped because the queue was full
//   drop_count, invalid_count   saturating statistics counters
//
// Optional feature: define REPLACE_EVENT_QUEUE_STATS_EN to build the statistics
// counters; otherwise drop_count and invalid_count are tied to 0.
module replace_event_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_invalid,
  input  logic [63:0]   in_old_ref,
  input  logic [63:0]   in_new_ref,
  input  logic [31:0]   in_shares,
  input  logic [31:0]   in_price,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_old_ref,
  output logic [63:0]   out_new_ref,
  output logic [31:0]   out_shares,
  output logic [31:0]   out_price,
  output logic [15:0]   out_seq,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic [15:0]   drop_count,
  output logic [15:0]   invalid_count
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] old_ref;
    logic [63:0] new_ref;
    logic [31:0] shares;
    logic [31:0] price;
    logic [15:0] seq;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_next;
  logic [15:0]   seq_q;
  logic          overflow_q;
  logic          push;
  logic          pop;
  logic          drop;

  // Handshake decode; a pop frees a slot so a push at full is still accepted.
  always_comb begin
    pop  = out_valid && out_ready;
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Control state: pointers, occupancy, sequence counter, sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq_q  <= seq_q + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_next;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Entry storage; contents are not reset, the empty-state mask hides them.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= '{old_ref: in_old_ref, new_ref: in_new_ref,
                       shares: in_shares, price: in_price, seq: seq_q};
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign overflow  = overflow_q;

  // Head payload, forced to zero while the queue is empty.
  always_comb begin
    out_old_ref = '0;
    out_new_ref = '0;
    out_shares  = '0;
    out_price   = '0;
    out_seq     = '0;
    if (out_valid) begin
      out_old_ref = head.old_ref;
      out_new_ref = head.new_ref;
      out_shares  = head.shares;
      out_price   = head.price;
      out_seq     = head.seq;
    end
  end

`ifdef REPLACE_EVENT_QUEUE_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] inv_cnt_q;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      inv_cnt_q  <= '0;
    end else begin
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (in_invalid && inv_cnt_q != 16'hFFFF) inv_cnt_q <= inv_cnt_q + 16'd1;
    end
  end

  assign drop_count    = drop_cnt_q;
  assign invalid_count = inv_cnt_q;
`else
  logic unused_invalid;
  assign unused_invalid = in_invalid;
  assign drop_count     = '0;
  assign invalid_count  = '0;
`endif

endmodule
